pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Program-counter register and instruction-fetch sequencer for KGP_RISC.
//  - Holds the architectural PC and fetches the instruction at that PC from instruction memory.
//  - Presents the fetched instruction to decode.
//  - Sends pc_plus4 to the branch-control logic and takes next_pc back from it.
//  - Loads next_pc when the control path retires the current instruction.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset; must be word-aligned
// PORTS
//  clk          in   1   system clock, rising edge
//  rst          in   1   asynchronous reset, active-high
//  next_pc      in   32  target PC from branch control
//  pc_advance   in   1   current instruction retires; load next_pc
//  halt         in   1   stop fetching after the current instruction retires
//  imem_ack     in   1   instruction memory: imem_rdata valid this cycle
//  imem_rdata   in   32  instruction memory read data
//  pc           out  32  current PC (registered)
//  pc_plus4     out  32  pc + 4, modulo 2^32 (combinational from pc)
//  imem_req     out  1   instruction memory read request
//  imem_addr    out  32  instruction memory address; equals pc
//  instr        out  32  latched instruction
//  instr_valid  out  1   instr is valid for decode
//  misaligned   out  1   sticky flag: next_pc[1:0] != 0 was loaded
// BEHAVIOUR
//  Reset (asynchronous, takes effect immediately, any state):
//   - pc = RESET_PC, state = FETCH, instr = 0, instr_valid = 0, misaligned = 0.
//  States:
//   - FETCH, HOLD, HALTED, ERROR; state is registered.
//   - imem_req = (state == FETCH), decoded combinationally.
//   - imem_addr = pc always.
//  FETCH:
//   - imem_req = 1 and instr_valid = 0. Wait any number of cycles for imem_ack.
//   - On imem_ack: instr <= imem_rdata, state -> HOLD. instr_valid goes high next cycle.
//   - Minimum fetch latency: ack in the first FETCH cycle gives instr_valid on the following cycle.
//   - pc_advance is ignored in FETCH, and pc does not change.
//  HOLD:
//   - instr_valid = 1. instr and pc stay stable until pc_advance.
//   - On pc_advance:
//     - pc <= next_pc.
//     - If next_pc[1:0] != 0: misaligned <= 1, state -> ERROR.
//     - Else if halt = 1 in the same cycle: state -> HALTED.
//     - Else: state -> FETCH.
//   - instr_valid drops on the cycle after pc_advance.
//   - halt without pc_advance has no effect in HOLD.
//  HALTED:
//   - imem_req = 0 and instr_valid = 0; pc holds the loaded next_pc.
//   - When halt deasserts: state -> FETCH the next cycle and fetch resumes at pc.
//  ERROR:
//   - imem_req = 0 and instr_valid = 0; misaligned = 1.
//   - pc holds the bad address. Only rst exits this state.
//  imem_ack outside FETCH is ignored: instr is unchanged and there is no state change.
//  Arithmetic:
//   - pc_plus4 = pc + 32'd4 with the carry discarded; 32'hFFFF_FFFC wraps to 0.
//   - next_pc is loaded verbatim; no sign or offset handling in this block.
// TESTING
//  1. Reset with RESET_PC = 0:
//     - imem_req = 1, imem_addr = 0.
//     - ack with rdata = 32'h1234_5678 on the 3rd cycle -> instr_valid = 1 the next cycle, instr = 32'h1234_5678.
//  2. Sequential fetch:
//     - In HOLD, pulse pc_advance with next_pc = pc_plus4 = 4 -> pc = 4, imem_addr = 4.
//     - instr_valid drops for at least 1 cycle, then the fetch repeats.
//  3. Branch and wrap:
//     - pc = 32'hFFFF_FFFC -> pc_plus4 = 0.
//     - pc_advance with next_pc = 32'h0000_0100 -> pc = 32'h100.
//     - pc_advance asserted during FETCH -> pc unchanged.
//  4. Halt and resume:
//     - pc_advance and halt together with next_pc = 8 -> HALTED: imem_req = 0, pc = 8.
//     - Deassert halt -> imem_req = 1 and imem_addr = 8 within 1 cycle.
//  5. Misaligned target:
//     - pc_advance with next_pc = 32'h0000_0006 -> misaligned = 1, imem_req stays 0.
//     - Further pc_advance and imem_ack have no effect; rst clears misaligned.
//  6. Async reset mid-fetch:
//     - Assert rst between clock edges while waiting for ack -> pc = RESET_PC, instr_valid = 0 with no clock edge.
//     - A stray imem_ack after reset is taken as the fetch of RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: fetch-unit bus bundle.
//   Branch-control side : next_pc, pc_advance, halt (in); pc, pc_plus4 (out)
//   Instruction memory  : imem_ack, imem_rdata (in); imem_req, imem_addr (out)
//   Decode side         : instr, instr_valid, misaligned (out)
// The master modport is the fetch unit; the slave modport is its environment.
interface pc_fetch_unit_if;
    logic [31:0] next_pc;
    logic        pc_advance;
    logic        halt;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic        instr_valid;
    logic        misaligned;

    modport master (
        input  next_pc, pc_advance, halt, imem_ack, imem_rdata,
        output pc, pc_plus4, imem_req, imem_addr, instr, instr_valid, misaligned
    );

    modport slave (
        output next_pc, pc_advance, halt, imem_ack, imem_rdata,
        input  pc, pc_plus4, imem_req, imem_addr, instr, instr_valid, misaligned
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction-fetch sequencer for KGP_RISC.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : pc_fetch_unit_if.master
//              - requests the instruction at pc from instruction memory,
//                latches it and presents it to decode with instr_valid
//              - exports pc / pc_plus4 to branch control, loads next_pc on
//                pc_advance, enters HALTED on halt or ERROR on a misaligned
//                target (sticky misaligned flag)
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    pc_fetch_unit_if.master bus
);

    localparam int unsigned XLEN    = 32;
    localparam int unsigned PC_STEP = 4;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2,
        ERROR  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic              instr_valid_q, instr_valid_d;
    logic              misaligned_q, misaligned_d;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            misaligned_q  <= misaligned_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        misaligned_d = misaligned_q;

        unique case (state_q)
            FETCH: begin
                // pc_advance is deliberately ignored until an instruction is held.
                if (bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.pc_advance) begin
                    pc_d = bus.next_pc;
                    // Misalignment takes priority over halt: the bad pc is kept for inspection.
                    if (bus.next_pc[1:0] != 2'b00) begin
                        misaligned_d = 1'b1;
                        state_d      = ERROR;
                    end else if (bus.halt) begin
                        state_d = HALTED;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            HALTED: begin
                if (!bus.halt) begin
                    state_d = FETCH;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // Registered copy of "next state is HOLD" so decode sees a clean flop output.
        instr_valid_d = (state_d == HOLD);
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_q + XLEN'(PC_STEP);
    assign bus.imem_req    = (state_q == FETCH);
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.misaligned  = misaligned_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed self-checking bench for pc_fetch_unit (RESET_PC = 0).
module tb_pc_fetch_unit;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    pc_fetch_unit_if bus ();

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs set before the call are sampled on this edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_once(input logic [31:0] data);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = data;
        step();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
    endtask

    task automatic advance(input logic [31:0] target, input logic with_halt);
        bus.pc_advance = 1'b1;
        bus.next_pc    = target;
        bus.halt       = with_halt;
        step();
        bus.pc_advance = 1'b0;
        bus.next_pc    = '0;
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        bus.next_pc    = '0;
        bus.pc_advance = 1'b0;
        bus.halt       = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;

        // 1. Reset state and first fetch with ack on the third cycle.
        step();
        step();
        check("rst_pc",          bus.pc,          32'h0);
        check("rst_instr",       bus.instr,       32'h0);
        check("rst_instr_valid", bus.instr_valid, 32'h0);
        check("rst_misaligned",  bus.misaligned,  32'h0);
        check("rst_imem_req",    bus.imem_req,    32'h1);
        check("rst_imem_addr",   bus.imem_addr,   32'h0);
        rst = 1'b0;
        step();
        check("f1_imem_req",     bus.imem_req,    32'h1);
        check("f1_instr_valid",  bus.instr_valid, 32'h0);
        step();
        check("f2_instr_valid",  bus.instr_valid, 32'h0);
        ack_once(32'h1234_5678);
        check("f3_instr_valid",  bus.instr_valid, 32'h1);
        check("f3_instr",        bus.instr,       32'h1234_5678);
        check("hold_imem_req",   bus.imem_req,    32'h0);
        check("hold_pc_plus4",   bus.pc_plus4,    32'h4);

        // Stray ack and lone halt in HOLD change nothing.
        ack_once(32'hDEAD_BEEF);
        check("hold_ack_instr",  bus.instr,       32'h1234_5678);
        check("hold_ack_valid",  bus.instr_valid, 32'h1);
        bus.halt = 1'b1;
        step();
        bus.halt = 1'b0;
        check("hold_halt_valid", bus.instr_valid, 32'h1);
        check("hold_halt_pc",    bus.pc,          32'h0);

        // 2. Sequential fetch.
        advance(32'h4, 1'b0);
        check("seq_pc",          bus.pc,          32'h4);
        check("seq_imem_addr",   bus.imem_addr,   32'h4);
        check("seq_instr_valid", bus.instr_valid, 32'h0);
        check("seq_imem_req",    bus.imem_req,    32'h1);

        // 3. pc_advance during FETCH is ignored.
        advance(32'hFFFF_FFFC, 1'b0);
        check("fetch_adv_pc",    bus.pc,          32'h4);
        check("fetch_adv_req",   bus.imem_req,    32'h1);
        ack_once(32'h0000_0004);
        check("seq_instr",       bus.instr,       32'h0000_0004);

        // Wrap and branch.
        advance(32'hFFFF_FFFC, 1'b0);
        check("wrap_pc",         bus.pc,          32'hFFFF_FFFC);
        check("wrap_pc_plus4",   bus.pc_plus4,    32'h0);
        ack_once(32'hFFFF_0000);
        advance(32'h0000_0100, 1'b0);
        check("branch_pc",       bus.pc,          32'h100);
        check("branch_addr",     bus.imem_addr,   32'h100);
        ack_once(32'h0000_0100);

        // 4. Halt and resume.
        advance(32'h8, 1'b1);
        check("halt_imem_req",   bus.imem_req,    32'h0);
        check("halt_pc",         bus.pc,          32'h8);
        check("halt_valid",      bus.instr_valid, 32'h0);
        ack_once(32'h5555_5555);
        check("halt_ack_req",    bus.imem_req,    32'h0);
        check("halt_ack_instr",  bus.instr,       32'h0000_0100);
        bus.halt = 1'b0;
        step();
        check("resume_req",      bus.imem_req,    32'h1);
        check("resume_addr",     bus.imem_addr,   32'h8);
        ack_once(32'h8888_8888);
        check("resume_instr",    bus.instr,       32'h8888_8888);
        check("resume_valid",    bus.instr_valid, 32'h1);

        // 5. Misaligned target; ERROR is sticky.
        advance(32'h0000_0006, 1'b0);
        check("mis_flag",        bus.misaligned,  32'h1);
        check("mis_pc",          bus.pc,          32'h6);
        check("mis_imem_req",    bus.imem_req,    32'h0);
        check("mis_valid",       bus.instr_valid, 32'h0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h7777_7777;
        advance(32'h0000_0020, 1'b0);
        bus.imem_ack   = 1'b0;
        step();
        check("err_pc",          bus.pc,          32'h6);
        check("err_req",         bus.imem_req,    32'h0);
        check("err_instr",       bus.instr,       32'h8888_8888);
        check("err_flag",        bus.misaligned,  32'h1);
        rst = 1'b1;
        #1;
        check("err_rst_flag",    bus.misaligned,  32'h0);
        check("err_rst_req",     bus.imem_req,    32'h1);
        #1;
        rst = 1'b0;

        // 6. Async reset while waiting for an ack at a non-reset pc.
        ack_once(32'hAAAA_0000);
        advance(32'h40, 1'b0);
        check("pre_rst_pc",      bus.pc,          32'h40);
        #2;
        rst = 1'b1;
        #1;
        check("async_pc",        bus.pc,          32'h0);
        check("async_valid",     bus.instr_valid, 32'h0);
        check("async_instr",     bus.instr,       32'h0);
        #1;
        rst = 1'b0;
        ack_once(32'hCAFE_F00D);
        check("stray_instr",     bus.instr,       32'hCAFE_F00D);
        check("stray_valid",     bus.instr_valid, 32'h1);
        check("stray_pc",        bus.pc,          32'h0);

        // Async reset from HOLD drops instr_valid without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        check("hold_rst_valid",  bus.instr_valid, 32'h0);
        check("hold_rst_instr",  bus.instr,       32'h0);
        #1;
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
